// File: rtl/ula.sv
// 32-bit ALU (ADD/SUB/AND/OR) with NZCV flags, plus registered copies of
// result and flags for consumers that need them held across a cycle.
module ula (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  ALUControl,
  output logic [31:0] Result,
  output logic [3:0]  ALUFlags,
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] ResultQ,
  output logic [3:0]  ALUFlagsQ
);

  logic        sub;
  logic        logic_op;
  logic [31:0] b_op;
  logic [32:0] sum_full;
  logic [31:0] sum;
  logic        cout;
  logic        flag_n, flag_z, flag_c, flag_v;

  assign sub      = ALUControl[0];
  assign logic_op = ALUControl[1];

  // One shared adder: SUB is A + ~B + 1, with the +1 fed in as carry-in.
  assign b_op     = sub ? ~B : B;
  assign sum_full = {1'b0, A} + {1'b0, b_op} + {32'd0, sub};
  assign sum      = sum_full[31:0];
  assign cout     = sum_full[32];

  always_comb begin
    Result = sum;
    case (ALUControl)
      2'b10:   Result = A & B;
      2'b11:   Result = A | B;
      default: Result = sum;
    endcase
  end

  assign flag_n = Result[31];
  assign flag_z = (Result == 32'd0);
  assign flag_c = ~logic_op & cout;
  // Overflow: effective operand signs agree but the sum sign does not.
  assign flag_v = ~logic_op & ~(sub ^ A[31] ^ B[31]) & (A[31] ^ sum[31]);

  assign ALUFlags = {flag_n, flag_z, flag_c, flag_v};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ResultQ   <= 32'd0;
      ALUFlagsQ <= 4'd0;
    end else begin
      ResultQ   <= Result;
      ALUFlagsQ <= ALUFlags;
    end
  end

endmodule

// File: tb/tb_ula.sv
// Directed-vector bench for ula: combinational result/flags, registered
// copies with async reset, and a randomized sweep against a signed/unsigned model.
module tb_ula;

  logic        clk;
  logic        reset_n;
  logic [31:0] A, B;
  logic [1:0]  ALUControl;
  logic [31:0] Result, ResultQ;
  logic [3:0]  ALUFlags, ALUFlagsQ;

  int n_chk  = 0;
  int n_pass = 0;

  ula dut (
    .A(A), .B(B), .ALUControl(ALUControl),
    .Result(Result), .ALUFlags(ALUFlags),
    .clk(clk), .reset_n(reset_n),
    .ResultQ(ResultQ), .ALUFlagsQ(ALUFlagsQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Drive after a rising edge, check combinational at the falling edge,
  // then check the registered copy after the following rising edge.
  task automatic run_vec(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f);
    @(posedge clk); #1;
    ALUControl = op; A = a; B = b;
    @(negedge clk);
    chk({tag, ".res"}, Result, r);
    chk({tag, ".flg"}, {28'd0, ALUFlags}, {28'd0, f});
    @(posedge clk); #1;
    chk({tag, ".resq"}, ResultQ, r);
    chk({tag, ".flgq"}, {28'd0, ALUFlagsQ}, {28'd0, f});
  endtask

  // Reference: C from unsigned compare/carry, V from 64-bit signed range.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, s;
    logic [63:0] u;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; r = 32'd0;
    case (op)
      2'b00: begin
        u = {32'd0, a} + {32'd0, b};
        r = u[31:0]; c = u[32];
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'b01: begin
        r = a - b; c = (a >= b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    f = {r[31], r == 32'd0, c, v};
  endtask

  logic [31:0] er, pr;
  logic [3:0]  ef, pf;

  initial begin
    reset_n = 1'b0; A = '0; B = '0; ALUControl = 2'b00;

    // Held in reset: registered outputs stay 0 while combinational tracks
    @(posedge clk); #1;
    A = 32'd3; B = 32'd4;
    @(negedge clk);
    chk("rst.resq", ResultQ, 32'd0);
    chk("rst.flgq", {28'd0, ALUFlagsQ}, 32'd0);
    chk("rst.res", Result, 32'd7);

    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.resq", ResultQ, 32'd7);
    chk("rel.flgq", {28'd0, ALUFlagsQ}, 32'd0);

    run_vec("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
    run_vec("add_ovf",  2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
    run_vec("sub_eq",   2'b01, 32'd5,         32'd5,         32'h0000_0000, 4'b0110);
    run_vec("sub_brw",  2'b01, 32'd0,         32'd1,         32'hFFFF_FFFF, 4'b1000);
    run_vec("sub_ovf",  2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
    run_vec("add_neg",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111);
    run_vec("sub_c",    2'b01, 32'd10,        32'd3,         32'h0000_0007, 4'b0010);
    run_vec("and",      2'b10, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 4'b0100);
    run_vec("or",       2'b11, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 4'b1000);

    // Mid-cycle async reset clears registered outputs at once
    #2 reset_n = 1'b0;
    #1;
    chk("mid.resq", ResultQ, 32'd0);
    chk("mid.flgq", {28'd0, ALUFlagsQ}, 32'd0);
    chk("mid.res", Result, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("mid.hold", ResultQ, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    pr = '0; pf = '0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        chk("rnd.resq", ResultQ, pr);
        chk("rnd.flgq", {28'd0, ALUFlagsQ}, {28'd0, pf});
      end
      ALUControl = 2'($urandom_range(3));
      case ($urandom_range(3))
        0:       begin A = $urandom; B = A; end
        1:       begin A = {$urandom_range(1), 31'h7FFF_FFFF}; B = $urandom_range(3); end
        default: begin A = $urandom; B = $urandom; end
      endcase
      model(ALUControl, A, B, er, ef);
      @(negedge clk);
      chk("rnd.res", Result, er);
      chk("rnd.flg", {28'd0, ALUFlags}, {28'd0, ef});
      pr = er; pf = ef;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
